// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the fetch/load-store memory arbiter.
// Covers state and owner encodings and the legal memory latency range.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam int unsigned MEM_LAT_MIN = 1;
    localparam int unsigned MEM_LAT_MAX = 4;
    localparam int unsigned LAT_W       = $clog2(MEM_LAT_MAX);

    // Latency counter load value; out-of-range latencies are clamped into the legal range.
    function automatic logic [LAT_W-1:0] lat_load(input int unsigned lat);
        int unsigned l;
        l = lat;
        if (l < MEM_LAT_MIN) l = MEM_LAT_MIN;
        if (l > MEM_LAT_MAX) l = MEM_LAT_MAX;
        return LAT_W'(l - 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter.
// The slave modport is the arbiter's view; master is the core/memory view.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32
);

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [3:0]        d_wstrb;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [3:0]        mem_wstrb;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_wstrb, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_wstrb, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick between fetch and data requests.
// On a conflict the port that did not own the previous access wins.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic   if_req_i,
    input  logic   d_req_i,
    input  owner_t last_owner_i,
    output logic   valid_o,
    output owner_t winner_o
);

    always_comb begin
        valid_o  = if_req_i | d_req_i;
        winner_o = OWN_IF;
        if (if_req_i && d_req_i) begin
            winner_o = (last_owner_i == OWN_D) ? OWN_IF : OWN_D;
        end else if (d_req_i) begin
            winner_o = OWN_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory between fetch and load/store ports,
// one access outstanding at a time, round-robin on simultaneous requests.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);

    localparam logic [LAT_W-1:0] LAT_LOAD = lat_load(MEM_LAT);

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    owner_t            last_owner_q, last_owner_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              op_we_q, op_we_d;
    logic              if_gnt_q, if_gnt_d;
    logic              d_gnt_q, d_gnt_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       d_rdata_q, d_rdata_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [3:0]        mem_wstrb_q, mem_wstrb_d;
    logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic   arb_valid;
    owner_t arb_winner;
    logic   grant;
    logic   lat_done;

    rr_arb2 u_rr_arb2 (
        .if_req_i     (bus.if_req),
        .d_req_i      (bus.d_req),
        .last_owner_i (last_owner_q),
        .valid_o      (arb_valid),
        .winner_o     (arb_winner)
    );

    assign grant = arb_valid && (state_q != WAIT);
    // The mem_en cycle is the first WAIT cycle and does not count, so capture lands
    // exactly MEM_LAT cycles after mem_en.
    assign lat_done = (state_q == WAIT) && !mem_en_q && (lat_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_IF;
            last_owner_q <= OWN_D;
            lat_q        <= '0;
            op_we_q      <= 1'b0;
            if_gnt_q     <= 1'b0;
            d_gnt_q      <= 1'b0;
            if_rvalid_q  <= 1'b0;
            d_rvalid_q   <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_wstrb_q  <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            lat_q        <= lat_d;
            op_we_q      <= op_we_d;
            if_gnt_q     <= if_gnt_d;
            d_gnt_q      <= d_gnt_d;
            if_rvalid_q  <= if_rvalid_d;
            d_rvalid_q   <= d_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_wstrb_q  <= mem_wstrb_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, RESP: state_d = arb_valid ? WAIT : IDLE;
            WAIT:       if (lat_done) state_d = RESP;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        lat_d        = lat_q;
        op_we_d      = op_we_q;
        if_gnt_d     = 1'b0;
        d_gnt_d      = 1'b0;
        if_rvalid_d  = 1'b0;
        d_rvalid_d   = 1'b0;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_wstrb_d  = '0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        if (grant) begin
            owner_d      = arb_winner;
            last_owner_d = arb_winner;
            lat_d        = LAT_LOAD;
            mem_en_d     = 1'b1;
            if (arb_winner == OWN_IF) begin
                if_gnt_d    = 1'b1;
                op_we_d     = 1'b0;
                mem_addr_d  = bus.if_addr[ADDR_W-1:2];
                mem_wdata_d = '0;
            end else begin
                d_gnt_d     = 1'b1;
                op_we_d     = bus.d_we;
                mem_we_d    = bus.d_we;
                mem_wstrb_d = bus.d_we ? bus.d_wstrb : 4'b0000;
                mem_addr_d  = bus.d_addr[ADDR_W-1:2];
                mem_wdata_d = bus.d_wdata;
            end
        end

        if ((state_q == WAIT) && !mem_en_q && (lat_q != '0)) begin
            lat_d = lat_q - 1'b1;
        end

        if (lat_done) begin
            if (owner_q == OWN_IF) begin
                if_rvalid_d = 1'b1;
                if_rdata_d  = bus.mem_rdata;
            end else begin
                d_rvalid_d = 1'b1;
                d_rdata_d  = op_we_q ? 32'h0 : bus.mem_rdata;
            end
        end
    end

    assign bus.if_gnt    = if_gnt_q;
    assign bus.d_gnt     = d_gnt_q;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wstrb = mem_wstrb_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with MEM_LAT=1, one with MEM_LAT=3,
// each attached to a small behavioural memory that drives junk outside its valid cycle.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32)) b1 ();
    mem_arbiter_if #(.ADDR_W(32)) b3 ();

    mem_arbiter #(.ADDR_W(32), .MEM_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    mem_arbiter #(.ADDR_W(32), .MEM_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

    logic [31:0] mem1 [256];
    logic [31:0] mem3 [256];
    logic        v1 = 1'b0;
    logic [7:0]  a1 = '0;
    logic [2:0]  v3 = '0;
    logic [7:0]  a3 [3];

    // Word i of memory 1 holds C0DE00ii (word 0x81 cleared), memory 3 holds 5EED00ii.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) begin
                mem1[i] <= (i == 8'h81) ? 32'h0 : (32'hC0DE_0000 | 32'(i));
                mem3[i] <= 32'h5EED_0000 | 32'(i);
            end
        end else if (b1.mem_en && b1.mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (b1.mem_wstrb[i]) mem1[b1.mem_addr[7:0]][8*i +: 8] <= b1.mem_wdata[8*i +: 8];
            end
        end
        v1    <= b1.mem_en && !b1.mem_we;
        a1    <= b1.mem_addr[7:0];
        v3    <= {v3[1:0], b3.mem_en && !b3.mem_we};
        a3[2] <= a3[1];
        a3[1] <= a3[0];
        a3[0] <= b3.mem_addr[7:0];
    end

    assign b1.mem_rdata = v1    ? mem1[a1]    : 32'hBAD0_BAD0;
    assign b3.mem_rdata = v3[2] ? mem3[a3[2]] : 32'hBAD0_BAD0;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        b1.if_req = 1'b0; b1.if_addr = '0; b1.d_req = 1'b0; b1.d_we = 1'b0;
        b1.d_addr = '0;   b1.d_wdata = '0; b1.d_wstrb = '0;
        b3.if_req = 1'b0; b3.if_addr = '0; b3.d_req = 1'b0; b3.d_we = 1'b0;
        b3.d_addr = '0;   b3.d_wdata = '0; b3.d_wstrb = '0;
        tick();
        tick();

        // Reset values
        chk1 ("rst_if_gnt",    b1.if_gnt,    1'b0);
        chk1 ("rst_d_gnt",     b1.d_gnt,     1'b0);
        chk1 ("rst_if_rvalid", b1.if_rvalid, 1'b0);
        chk1 ("rst_d_rvalid",  b1.d_rvalid,  1'b0);
        chk1 ("rst_mem_en",    b1.mem_en,    1'b0);
        chk1 ("rst_mem_we",    b1.mem_we,    1'b0);
        chk32("rst_mem_wstrb", 32'(b1.mem_wstrb), 32'h0);
        chk32("rst_mem_addr",  32'(b1.mem_addr),  32'h0);
        chk32("rst_mem_wdata", b1.mem_wdata, 32'h0);
        chk32("rst_if_rdata",  b1.if_rdata,  32'h0);
        chk32("rst_d_rdata",   b1.d_rdata,   32'h0);
        chk1 ("rst3_mem_en",   b3.mem_en,    1'b0);

        // Both ports held continuously: IF, D, IF, D with one grant every 3 cycles
        rst = 1'b0;
        b1.if_addr = 32'h100; b1.d_addr = 32'h10; b1.d_we = 1'b0;
        b1.if_req = 1'b1; b1.d_req = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            int  slot;
            int  rslot;
            logic gk;
            logic rk;
            tick();
            slot  = (k - 1) / 3;
            rslot = k / 3 - 1;
            gk    = ((k - 1) % 3 == 0);
            rk    = (k % 3 == 0);
            chk1("alt_if_gnt",    b1.if_gnt,    gk && (slot % 2 == 0));
            chk1("alt_d_gnt",     b1.d_gnt,     gk && (slot % 2 == 1));
            chk1("alt_mem_en",    b1.mem_en,    gk);
            chk1("alt_if_rvalid", b1.if_rvalid, rk && (rslot % 2 == 0));
            chk1("alt_d_rvalid",  b1.d_rvalid,  rk && (rslot % 2 == 1));
            if (rk && (rslot % 2 == 0)) chk32("alt_if_rdata", b1.if_rdata, 32'hC0DE_0040);
            if (rk && (rslot % 2 == 1)) chk32("alt_d_rdata",  b1.d_rdata,  32'hC0DE_0004);
        end
        b1.if_req = 1'b0; b1.d_req = 1'b0;
        tick();
        chk1("alt_idle_mem_en", b1.mem_en, 1'b0);

        // Single fetch from 0x100 after a fresh reset (rdata starts at 0)
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk32("fetch_pre_rdata", b1.if_rdata, 32'h0);
        b1.if_req = 1'b1;
        tick();
        chk1 ("fetch_gnt",      b1.if_gnt, 1'b1);
        chk1 ("fetch_no_dgnt",  b1.d_gnt,  1'b0);
        chk1 ("fetch_mem_en",   b1.mem_en, 1'b1);
        chk1 ("fetch_mem_we",   b1.mem_we, 1'b0);
        chk32("fetch_mem_addr", 32'(b1.mem_addr), 32'h40);
        b1.if_req = 1'b0;
        tick();
        chk1 ("fetch_wait_en",   b1.mem_en,    1'b0);
        chk1 ("fetch_wait_rv",   b1.if_rvalid, 1'b0);
        tick();
        chk1 ("fetch_rvalid",    b1.if_rvalid, 1'b1);
        chk32("fetch_rdata",     b1.if_rdata,  32'hC0DE_0040);
        chk1 ("fetch_no_drv",    b1.d_rvalid,  1'b0);
        tick();
        chk1 ("fetch_rv_pulse",  b1.if_rvalid, 1'b0);

        // Write 0xDEADBEEF to 0x204 with byte enables 0x3, then read it back
        b1.d_req = 1'b1; b1.d_we = 1'b1; b1.d_addr = 32'h204;
        b1.d_wdata = 32'hDEAD_BEEF; b1.d_wstrb = 4'h3;
        tick();
        chk1 ("wr_gnt",       b1.d_gnt,  1'b1);
        chk1 ("wr_mem_en",    b1.mem_en, 1'b1);
        chk1 ("wr_mem_we",    b1.mem_we, 1'b1);
        chk32("wr_mem_wstrb", 32'(b1.mem_wstrb), 32'h3);
        chk32("wr_mem_addr",  32'(b1.mem_addr),  32'h81);
        chk32("wr_mem_wdata", b1.mem_wdata, 32'hDEAD_BEEF);
        b1.d_req = 1'b0;
        tick();
        chk1 ("wr_wait_rv",   b1.d_rvalid, 1'b0);
        tick();
        chk1 ("wr_ack",       b1.d_rvalid, 1'b1);
        chk32("wr_ack_rdata", b1.d_rdata,  32'h0);
        chk32("wr_if_hold",   b1.if_rdata, 32'hC0DE_0040);
        tick();
        b1.d_req = 1'b1; b1.d_we = 1'b0;
        tick();
        chk1 ("rb_gnt",       b1.d_gnt,  1'b1);
        chk1 ("rb_mem_we",    b1.mem_we, 1'b0);
        chk32("rb_mem_wstrb", 32'(b1.mem_wstrb), 32'h0);
        b1.d_req = 1'b0;
        tick();
        tick();
        chk1 ("rb_rvalid",    b1.d_rvalid, 1'b1);
        chk32("rb_rdata",     b1.d_rdata,  32'h0000_BEEF);
        tick();

        // Data request raised and withdrawn while a fetch is in flight
        b1.if_req = 1'b1; b1.d_addr = 32'h10;
        tick();
        chk1("wd_if_gnt", b1.if_gnt, 1'b1);
        b1.if_req = 1'b0; b1.d_req = 1'b1;
        tick();
        b1.d_req = 1'b0;
        tick();
        chk1("wd_if_rvalid", b1.if_rvalid, 1'b1);
        chk1("wd_no_dgnt0",  b1.d_gnt,     1'b0);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk1("wd_no_dgnt", b1.d_gnt,  1'b0);
            chk1("wd_no_mem",  b1.mem_en, 1'b0);
        end

        // Reset during WAIT: response dropped, fetch wins the next conflict
        b1.if_req = 1'b1;
        tick();
        chk1("rw_gnt", b1.if_gnt, 1'b1);
        b1.if_req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk1 ("rw_if_gnt",   b1.if_gnt,    1'b0);
        chk1 ("rw_mem_en",   b1.mem_en,    1'b0);
        chk1 ("rw_rvalid",   b1.if_rvalid, 1'b0);
        chk32("rw_if_rdata", b1.if_rdata,  32'h0);
        chk32("rw_d_rdata",  b1.d_rdata,   32'h0);
        chk32("rw_mem_addr", 32'(b1.mem_addr), 32'h0);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk1("rw_late_rv", b1.if_rvalid, 1'b0);
        end
        b1.if_req = 1'b1; b1.d_req = 1'b1;
        tick();
        chk1("rw_conf_if", b1.if_gnt, 1'b1);
        chk1("rw_conf_d",  b1.d_gnt,  1'b0);
        b1.if_req = 1'b0; b1.d_req = 1'b0;
        tick();
        tick();

        // MEM_LAT=3: rvalid 5 cycles after request, next grant follows the rvalid cycle
        b3.if_addr = 32'h100; b3.if_req = 1'b1;
        tick();
        chk1 ("l3_if_gnt",   b3.if_gnt, 1'b1);
        chk1 ("l3_mem_en",   b3.mem_en, 1'b1);
        chk32("l3_mem_addr", 32'(b3.mem_addr), 32'h40);
        b3.if_req = 1'b0; b3.d_addr = 32'h20; b3.d_we = 1'b0; b3.d_req = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            tick();
            chk1("l3_if_rvalid", b3.if_rvalid, k == 5);
            chk1("l3_d_gnt_hold", b3.d_gnt,    1'b0);
            chk1("l3_mem_en_off", b3.mem_en,   1'b0);
            if (k == 5) chk32("l3_if_rdata", b3.if_rdata, 32'h5EED_0040);
        end
        tick();
        chk1 ("l3_d_gnt",      b3.d_gnt,  1'b1);
        chk1 ("l3_d_mem_en",   b3.mem_en, 1'b1);
        chk32("l3_d_mem_addr", 32'(b3.mem_addr), 32'h8);
        b3.d_req = 1'b0;
        for (int k = 7; k <= 10; k++) begin
            tick();
            chk1("l3_d_rvalid", b3.d_rvalid, k == 10);
            if (k == 10) chk32("l3_d_rdata", b3.d_rdata, 32'h5EED_0008);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
